// File: rtl/instr_assembler_pkg.sv
// instr_assembler_pkg: shared state encoding, size codes and entry field widths
package instr_assembler_pkg;
  localparam logic [1:0] S_OP = 2'd0;
  localparam logic [1:0] S_LO = 2'd1;
  localparam logic [1:0] S_HI = 2'd2;
  localparam logic [1:0] SZ1 = 2'd1;
  localparam logic [1:0] SZ2 = 2'd2;
  localparam logic [1:0] SZ3 = 2'd3;
  localparam int OPC_W = 8;
  localparam int OPR_W = 16;
  localparam int SIZE_W = 2;
endpackage

// File: rtl/instr_assembler_opsize.sv
// opsize_lut: combinational opcode to {size, illegal} lookup
module opsize_lut
  import instr_assembler_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  output logic [SIZE_W-1:0] size,
  output logic              illegal
);
  // unknown opcodes are treated as one-byte illegal instructions
  always_comb begin
    size = SZ1;
    illegal = 1'b0;
    case (opcode)
      8'h0A, 8'h18, 8'h2A, 8'h38, 8'h4A, 8'h58, 8'h6A, 8'h78, 8'h88, 8'h8A, 8'h98,
      8'h9A, 8'hA8, 8'hAA, 8'hB8, 8'hBA, 8'hC8, 8'hCA, 8'hD8, 8'hE8, 8'hEA, 8'hF8: size = SZ1;
      8'h4C: size = SZ3;
      8'h05, 8'h09, 8'h10, 8'h29, 8'h30, 8'h45, 8'h49, 8'h50, 8'h69, 8'h70, 8'h84,
      8'h85, 8'h86, 8'h90, 8'hA0, 8'hA2, 8'hA4, 8'hA5, 8'hA6, 8'hA9, 8'hB0, 8'hC0,
      8'hC4, 8'hC5, 8'hC6, 8'hC9, 8'hD0, 8'hE0, 8'hE4, 8'hE6, 8'hE9, 8'hF0: size = SZ2;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_assembler.sv
// instr_assembler: packs a fetched byte stream into decoded instruction entries in a FIFO
module instr_assembler
  import instr_assembler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [PC_W-1:0]            flush_pc,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       byte_ready,
  output logic [PC_W-1:0]            fetch_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPC_W-1:0]           out_opcode,
  output logic [OPR_W-1:0]           out_operand,
  output logic [SIZE_W-1:0]          out_size,
  output logic [PC_W-1:0]            out_pc,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  logic [1:0] state, nxt_state;
  logic [OPC_W-1:0] cur_op, cur_lo, e_op;
  logic [SIZE_W-1:0] cur_size, lut_size, e_size;
  logic cur_ill, lut_ill, e_ill;
  logic [PC_W-1:0] cur_pc, e_pc;
  logic [OPR_W-1:0] e_opr;
  logic [OPC_W-1:0] q_op [DEPTH];
  logic [OPR_W-1:0] q_opr [DEPTH];
  logic [SIZE_W-1:0] q_size [DEPTH];
  logic q_ill [DEPTH];
  logic [PC_W-1:0] q_pc [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic full, acc, pop, push;
  opsize_lut u_lut (.opcode(byte_data), .size(lut_size), .illegal(lut_ill));
  assign full = count == CW'(DEPTH);
  assign byte_ready = !rst && !flush && !full;
  assign acc = byte_valid && byte_ready;
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready && !flush;
  assign out_opcode = out_valid ? q_op[rd_ptr] : '0;
  assign out_operand = out_valid ? q_opr[rd_ptr] : '0;
  assign out_size = out_valid ? q_size[rd_ptr] : '0;
  assign out_illegal = out_valid ? q_ill[rd_ptr] : 1'b0;
  assign out_pc = out_valid ? q_pc[rd_ptr] : '0;
  // entry being completed by the current byte, and whether it completes now
  always_comb begin
    e_op = state == S_OP ? byte_data : cur_op;
    e_size = state == S_OP ? lut_size : cur_size;
    e_ill = state == S_OP ? lut_ill : cur_ill;
    e_pc = state == S_OP ? fetch_pc : cur_pc;
    e_opr = state == S_HI ? {byte_data, cur_lo} : state == S_LO ? {8'h00, byte_data} : '0;
    push = acc && (state == S_HI || e_size == SZ1 || (state == S_LO && e_size == SZ2));
    nxt_state = !acc ? state : push ? S_OP : state == S_OP ? S_LO : S_HI;
  end
  // control: state, fetch address, queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= S_OP;
      fetch_pc <= rst ? '0 : flush_pc;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= nxt_state;
      if (acc) fetch_pc <= fetch_pc + PC_W'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // datapath: partial instruction holding registers and queue storage
  always_ff @(posedge clk) begin
    if (acc && state == S_OP) begin
      cur_op <= byte_data;
      cur_size <= lut_size;
      cur_ill <= lut_ill;
      cur_pc <= fetch_pc;
    end
    if (acc && state == S_LO) cur_lo <= byte_data;
    if (push) begin
      q_op[wr_ptr] <= e_op;
      q_opr[wr_ptr] <= e_opr;
      q_size[wr_ptr] <= e_size;
      q_ill[wr_ptr] <= e_ill;
      q_pc[wr_ptr] <= e_pc;
    end
  end
endmodule

// File: tb/tb_instr_assembler.sv
// tb_instr_assembler: scoreboard bench with a byte-list reference model of the assembler
module tb_instr_assembler;
  localparam int DEPTH = 4;
  localparam int PC_W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [PC_W-1:0] flush_pc = '0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic byte_ready;
  logic [PC_W-1:0] fetch_pc;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [7:0] out_opcode;
  logic [15:0] out_operand;
  logic [1:0] out_size;
  logic [PC_W-1:0] out_pc;
  logic out_illegal;
  logic [2:0] count;
  int tests = 0;
  int errors = 0;
  bit chk_en = 0;
  typedef struct {
    logic [7:0] op;
    logic [15:0] opr;
    logic [1:0] sz;
    logic ill;
    logic [PC_W-1:0] pc;
  } ent_t;
  ent_t exp_q[$];
  logic [7:0] pend[$];
  logic [PC_W-1:0] pend_pc;
  logic [PC_W-1:0] mpc = '0;
  logic [7:0] s1 [22] = '{8'h0A, 8'h18, 8'h2A, 8'h38, 8'h4A, 8'h58, 8'h6A, 8'h78, 8'h88, 8'h8A, 8'h98,
                          8'h9A, 8'hA8, 8'hAA, 8'hB8, 8'hBA, 8'hC8, 8'hCA, 8'hD8, 8'hE8, 8'hEA, 8'hF8};
  logic [7:0] s2 [32] = '{8'h05, 8'h09, 8'h10, 8'h29, 8'h30, 8'h45, 8'h49, 8'h50, 8'h69, 8'h70, 8'h84,
                          8'h85, 8'h86, 8'h90, 8'hA0, 8'hA2, 8'hA4, 8'hA5, 8'hA6, 8'hA9, 8'hB0, 8'hC0,
                          8'hC4, 8'hC5, 8'hC6, 8'hC9, 8'hD0, 8'hE0, 8'hE4, 8'hE6, 8'hE9, 8'hF0};

  instr_assembler #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .fetch_pc(fetch_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_operand(out_operand), .out_size(out_size),
    .out_pc(out_pc), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  function automatic bit in_s1(input logic [7:0] op);
    in_s1 = 0;
    foreach (s1[i]) if (s1[i] == op) in_s1 = 1;
  endfunction

  function automatic bit in_s2(input logic [7:0] op);
    in_s2 = 0;
    foreach (s2[i]) if (s2[i] == op) in_s2 = 1;
  endfunction

  function automatic int size_of(input logic [7:0] op);
    size_of = op == 8'h4C ? 3 : in_s2(op) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: collect accepted bytes until the opcode's length is reached
  always @(posedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
      pend.delete();
      mpc = rst ? '0 : flush_pc;
    end else if (byte_valid && byte_ready) begin
      ent_t e;
      if (pend.size() == 0) pend_pc = mpc;
      pend.push_back(byte_data);
      mpc = mpc + 1'b1;
      if (pend.size() == size_of(pend[0])) begin
        e.op = pend[0];
        e.sz = 2'(size_of(pend[0]));
        e.ill = !(in_s1(pend[0]) || in_s2(pend[0]) || pend[0] == 8'h4C);
        e.pc = pend_pc;
        e.opr = e.sz == 2'd1 ? 16'h0000 : e.sz == 2'd2 ? {8'h00, pend[1]} : {pend[2], pend[1]};
        exp_q.push_back(e);
        pend.delete();
      end
    end
  end

  // monitor: occupancy, ready, idle outputs and popped entries against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("byte_ready", 64'(byte_ready), 64'(!rst && !flush && exp_q.size() < DEPTH));
      chk("fetch_pc", 64'(fetch_pc), 64'(mpc));
      if (exp_q.size() == 0)
        chk("idle_out", {out_valid, out_opcode, out_operand, out_size, out_illegal, out_pc}, 64'd0);
      else if (!rst && !flush && out_valid && out_ready) begin
        ent_t e;
        e = exp_q.pop_front();
        chk("pop_opcode", 64'(out_opcode), 64'(e.op));
        chk("pop_operand", 64'(out_operand), 64'(e.opr));
        chk("pop_size", 64'(out_size), 64'(e.sz));
        chk("pop_illegal", 64'(out_illegal), 64'(e.ill));
        chk("pop_pc", 64'(out_pc), 64'(e.pc));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; flush = 0; byte_valid = 0; out_ready = 0;
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_state", {fetch_pc, 3'(count), out_valid, byte_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic send(input logic [7:0] b);
    bit done = 0;
    byte_valid = 1; byte_data = b;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    byte_valid = 0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    out_ready = 1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    out_ready = 0;
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [7:0] pick();
    int r = $urandom_range(0, 3);
    pick = r == 0 ? s1[$urandom_range(0, 21)] : r == 1 ? s2[$urandom_range(0, 31)] :
           r == 2 ? 8'h4C : 8'($urandom);
  endfunction

  initial begin
    do_reset();
    send(8'hA9); send(8'h42);
    @(negedge clk);
    chk("t1_fetch_pc", 64'(fetch_pc), 64'h2);
    chk("t1_latency", {out_valid, 3'(count)}, {1'b1, 3'd1});
    chk("t1_entry", {out_opcode, out_operand, out_size, out_pc}, {8'hA9, 16'h0042, 2'd2, 16'h0000});
    drain();
    do_reset();
    send(8'h4C); send(8'h00); send(8'h80); send(8'hE8);
    @(negedge clk);
    chk("t2_count", 64'(count), 64'd2);
    chk("t2_head", {out_opcode, out_operand, out_size, out_pc}, {8'h4C, 16'h8000, 2'd3, 16'h0000});
    drain();
    do_reset();
    repeat (4) send(8'hE8);
    byte_valid = 1; byte_data = 8'hE8;
    @(negedge clk);
    chk("t3_full", {3'(count), byte_ready}, {3'd4, 1'b0});
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk);
    chk("t3_full_pop", {3'(count), byte_ready, fetch_pc}, {3'd4, 1'b0, 16'h0004});
    @(posedge clk); #1;
    out_ready = 0;
    @(negedge clk);
    chk("t3_after_pop", {3'(count), byte_ready}, {3'd3, 1'b1});
    @(posedge clk); #1;
    byte_valid = 0;
    @(negedge clk);
    chk("t3_refill", {3'(count), fetch_pc}, {3'd4, 16'h0005});
    drain();
    do_reset();
    send(8'h4C); send(8'h00);
    flush = 1; flush_pc = 16'h0200;
    @(posedge clk); #1;
    flush = 0;
    send(8'hA9); send(8'h07);
    @(negedge clk);
    chk("t4_flush", {3'(count), out_opcode, out_operand, out_pc, fetch_pc}, {3'd1, 8'hA9, 16'h0007, 16'h0200, 16'h0202});
    drain();
    send(8'h02); send(8'hA9); send(8'h05);
    @(negedge clk);
    chk("t5_illegal", {3'(count), out_opcode, out_size, out_illegal}, {3'd2, 8'h02, 2'd1, 1'b1});
    drain();
    flush = 1; flush_pc = 16'hFFFF;
    @(posedge clk); #1;
    flush = 0;
    send(8'h69); send(8'h01);
    @(negedge clk);
    chk("t6_wrap", {3'(count), out_pc, fetch_pc, out_operand}, {3'd1, 16'hFFFF, 16'h0001, 16'h0001});
    @(posedge clk); #1;
    out_ready = 1;
    send(8'hE8);
    @(negedge clk);
    chk("t6_push_pop", {3'(count), out_opcode}, {3'd1, 8'hE8});
    drain();
    for (int c = 0; c < 3000; c++) begin
      int r;
      @(posedge clk); #1;
      r = $urandom_range(0, 199);
      rst = r == 0;
      flush = r >= 1 && r <= 4;
      flush_pc = 16'($urandom);
      byte_valid = $urandom_range(0, 3) != 0;
      byte_data = pick();
      out_ready = $urandom_range(0, 2) != 0;
    end
    rst = 0; flush = 0; byte_valid = 0;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
